// File: rtl/sdram_act_pre_insert_gen_if.sv
// AXI-stream style command channel used on both sides of the ACT/PRE insertion
// stage. The data and sideband widths are set by the instantiator.
interface sdram_act_pre_insert_gen_if #(
  parameter int DATA_W = 31,
  parameter int USER_W = 9
);
  logic [DATA_W-1:0] data;
  logic [USER_W-1:0] user;
  logic              valid;
  logic              ready;

  modport master (output data, output user, output valid, input  ready);
  modport slave  (input  data, input  user, input  valid, output ready);
endinterface

// File: rtl/sdram_act_pre_insert_gen.sv
// SDRAM activate/precharge insertion stage.
// Sits between the user command stream and the SDRAM command sequencer. It
// tracks the open row of every bank and, in front of a read/write, emits
// PRECHARGE and/or ACTIVE as needed. In front of AUTO REFRESH it emits
// PRECHARGE ALL when any bank is open. Output is combinational from the held
// input, so a page hit goes through with zero added latency.

// Per-bank tracker: open flag (reset) and open row (not reset).
module sdram_api_bank_trk #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_open,
  input  logic              clr_open,
  input  logic [ADDR_W-1:0] row_d,
  output logic              open_q,
  output logic [ADDR_W-1:0] row_q
);
  // Open flag: an ACTIVE opens the bank, any closing command clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        open_q <= 1'b0;
    else if (set_open) open_q <= 1'b1;
    else if (clr_open) open_q <= 1'b0;
  end

  // Row register only matters while the bank is open, so it has no reset.
  always_ff @(posedge clk) begin
    if (set_open) row_q <= row_d;
  end
endmodule

module sdram_act_pre_insert_gen #(
  parameter int    BANK_N      = 4,
  parameter int    ADDR_W      = 13,
  parameter int    BURST_LEN   = -1,
  parameter string PAGE_POLICY = "open",
  parameter int    USER_W      = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sdram_act_pre_insert_gen_if.slave   s_axis_usr_cmd,
  sdram_act_pre_insert_gen_if.master  m_axis_inserted_cmd,
  output logic [BANK_N-1:0]           bank_open_o
);
  localparam int BA_W = $clog2(BANK_N);

  localparam logic [2:0] CMD_ACT = 3'b000;
  localparam logic [2:0] CMD_PRE = 3'b001;
  localparam logic [2:0] CMD_WR  = 3'b010;
  localparam logic [2:0] CMD_RD  = 3'b011;
  localparam logic [2:0] CMD_REF = 3'b100;

  // How A10 is produced on read/write: 0 = forced low (full page bursts
  // cannot auto-precharge), 1 = forced high (close page), 2 = from user.
  localparam int A10_MODE = (BURST_LEN == -1)         ? 0 :
                            (PAGE_POLICY == "close")  ? 1 : 2;

  // PRECHARGE ALL address: only A10 set.
  localparam logic [ADDR_W-1:0] A10_ONLY = ADDR_W'(1024);

  typedef enum logic [1:0] {ST_PASS, ST_ACT, ST_RW, ST_REF} state_e;

  state_e state_q, state_d;

  // Input command fields: {ba, row, addr, cmd}
  logic [BA_W-1:0]   in_ba;
  logic [ADDR_W-1:0] in_row;
  logic [ADDR_W-1:0] in_addr;
  logic [2:0]        in_cmd;
  logic              s_valid, m_ready;

  assign in_cmd  = s_axis_usr_cmd.data[2:0];
  assign in_addr = s_axis_usr_cmd.data[ADDR_W+2:3];
  assign in_row  = s_axis_usr_cmd.data[2*ADDR_W+2:ADDR_W+3];
  assign in_ba   = s_axis_usr_cmd.data[BA_W+2*ADDR_W+2:2*ADDR_W+3];
  assign s_valid = s_axis_usr_cmd.valid;
  assign m_ready = m_axis_inserted_cmd.ready;

  // Output command fields and handshake
  logic [BA_W-1:0]   out_ba;
  logic [ADDR_W-1:0] out_addr;
  logic [2:0]        out_cmd;
  logic              m_valid, s_ready, m_hs;

  // Bank tracking state
  logic [BANK_N-1:0]             open_vec;
  logic [BANK_N-1:0][ADDR_W-1:0] row_vec;
  logic [BANK_N-1:0]             bank_set, bank_clr;

  logic              in_rw, in_open, bank_hit, rw_a10;
  logic [ADDR_W-1:0] rw_addr;

  assign in_rw    = (in_cmd == CMD_WR) || (in_cmd == CMD_RD);
  assign in_open  = open_vec[in_ba];
  assign bank_hit = in_open && (row_vec[in_ba] == in_row);

  // Read/write address with the page-policy A10 applied.
  always_comb begin
    rw_a10 = 1'b0;
    if (A10_MODE == 1)      rw_a10 = 1'b1;
    else if (A10_MODE == 2) rw_a10 = in_addr[10];
    rw_addr     = in_addr;
    rw_addr[10] = rw_a10;
  end

  // State register; reset abandons any partial sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_PASS;
    else        state_q <= state_d;
  end

  // Next state and emitted command. Input ready only on the final beat.
  always_comb begin
    state_d  = state_q;
    out_cmd  = in_cmd;
    out_ba   = in_ba;
    out_addr = in_addr;
    m_valid  = 1'b0;
    s_ready  = 1'b0;
    case (state_q)
      ST_PASS: begin
        if (s_valid) begin
          m_valid = 1'b1;
          if (in_rw) begin
            if (bank_hit) begin
              out_addr = rw_addr;
              s_ready  = m_ready;
            end else if (in_open) begin
              // Row conflict: close this bank first.
              out_cmd  = CMD_PRE;
              out_addr = '0;
              if (m_ready) state_d = ST_ACT;
            end else begin
              out_cmd  = CMD_ACT;
              out_addr = in_row;
              if (m_ready) state_d = ST_RW;
            end
          end else if ((in_cmd == CMD_REF) && (|open_vec)) begin
            out_cmd  = CMD_PRE;
            out_ba   = '0;
            out_addr = A10_ONLY;
            if (m_ready) state_d = ST_REF;
          end else begin
            s_ready = m_ready;
          end
        end
      end
      ST_ACT: begin
        m_valid  = s_valid;
        out_cmd  = CMD_ACT;
        out_addr = in_row;
        if (s_valid && m_ready) state_d = ST_RW;
      end
      ST_RW: begin
        m_valid  = s_valid;
        out_addr = rw_addr;
        s_ready  = s_valid && m_ready;
        if (s_valid && m_ready) state_d = ST_PASS;
      end
      ST_REF: begin
        m_valid = s_valid;
        s_ready = s_valid && m_ready;
        if (s_valid && m_ready) state_d = ST_PASS;
      end
      default: state_d = ST_PASS;
    endcase
  end

  assign m_hs = m_valid && m_ready;

  // Tracking events decoded from the command actually handed downstream.
  logic trk_act, trk_pre_one, trk_pre_all, trk_rw_cls;
  assign trk_act     = m_hs && (out_cmd == CMD_ACT);
  assign trk_pre_one = m_hs && (out_cmd == CMD_PRE) && !out_addr[10];
  assign trk_pre_all = m_hs && (out_cmd == CMD_PRE) &&  out_addr[10];
  assign trk_rw_cls  = m_hs && ((out_cmd == CMD_WR) || (out_cmd == CMD_RD)) && out_addr[10];

  // One tracker per bank.
  for (genvar b = 0; b < BANK_N; b++) begin : g_bank
    logic sel;
    assign sel         = (out_ba == BA_W'(b));
    assign bank_set[b] = trk_act && sel;
    assign bank_clr[b] = trk_pre_all || ((trk_pre_one || trk_rw_cls) && sel);

    sdram_api_bank_trk #(.ADDR_W(ADDR_W)) u_trk (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_open (bank_set[b]),
      .clr_open (bank_clr[b]),
      .row_d    (out_addr),
      .open_q   (open_vec[b]),
      .row_q    (row_vec[b])
    );
  end

  assign s_axis_usr_cmd.ready      = s_ready;
  assign m_axis_inserted_cmd.data  = {out_ba, out_addr, out_cmd};
  assign m_axis_inserted_cmd.user  = s_axis_usr_cmd.user;
  assign m_axis_inserted_cmd.valid = m_valid;
  assign bank_open_o               = open_vec;
endmodule

// File: tb/tb_sdram_act_pre_insert_gen.sv
// Bench for the ACT/PRE insertion stage: directed commands, expected output
// beats queued per DUT, a negedge monitor compares every presented beat.
module tb_sdram_act_pre_insert_gen;
  localparam int BANK_N = 4;
  localparam int ADDR_W = 13;
  localparam int USER_W = 9;
  localparam int BA_W   = 2;
  localparam int ID_W   = BA_W + 2*ADDR_W + 3;
  localparam int OD_W   = BA_W + ADDR_W + 3;

  localparam logic [2:0] C_ACT = 3'b000;
  localparam logic [2:0] C_PRE = 3'b001;
  localparam logic [2:0] C_WR  = 3'b010;
  localparam logic [2:0] C_RD  = 3'b011;
  localparam logic [2:0] C_REF = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ID_W-1:0]   s_data = '0;
  logic [USER_W-1:0] s_user = '0;
  logic              s_valid_a = 1'b0, s_valid_b = 1'b0;
  logic              m_ready = 1'b1;
  bit                rnd_ready = 1'b0;
  logic [BANK_N-1:0] open_a, open_b;

  sdram_act_pre_insert_gen_if #(.DATA_W(ID_W), .USER_W(USER_W)) sa_if ();
  sdram_act_pre_insert_gen_if #(.DATA_W(OD_W), .USER_W(USER_W)) ma_if ();
  sdram_act_pre_insert_gen_if #(.DATA_W(ID_W), .USER_W(USER_W)) sb_if ();
  sdram_act_pre_insert_gen_if #(.DATA_W(OD_W), .USER_W(USER_W)) mb_if ();

  assign sa_if.data  = s_data;
  assign sa_if.user  = s_user;
  assign sa_if.valid = s_valid_a;
  assign ma_if.ready = m_ready;
  assign sb_if.data  = s_data;
  assign sb_if.user  = s_user;
  assign sb_if.valid = s_valid_b;
  assign mb_if.ready = m_ready;

  // A: open page, full-page bursts (A10 always 0 on read/write)
  sdram_act_pre_insert_gen #(.BANK_N(BANK_N), .ADDR_W(ADDR_W), .BURST_LEN(-1),
    .PAGE_POLICY("open"), .USER_W(USER_W)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_axis_usr_cmd(sa_if),
    .m_axis_inserted_cmd(ma_if), .bank_open_o(open_a));

  // B: close page, BL=4 (A10 forced 1 on read/write)
  sdram_act_pre_insert_gen #(.BANK_N(BANK_N), .ADDR_W(ADDR_W), .BURST_LEN(4),
    .PAGE_POLICY("close"), .USER_W(USER_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_axis_usr_cmd(sb_if),
    .m_axis_inserted_cmd(mb_if), .bank_open_o(open_b));

  typedef struct {
    logic [OD_W-1:0]   data;
    logic [USER_W-1:0] user;
    bit                last;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [ID_W-1:0] mk_in(int ba, int row, int addr, logic [2:0] cmd);
    return {BA_W'(ba), ADDR_W'(row), ADDR_W'(addr), cmd};
  endfunction

  function automatic logic [OD_W-1:0] mk_out(int ba, int addr, logic [2:0] cmd);
    return {BA_W'(ba), ADDR_W'(addr), cmd};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [OD_W-1:0] d, input logic [USER_W-1:0] u,
                      input bit last);
    exp_t e;
    e.data = d; e.user = u; e.last = last;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // Monitors: every presented beat must match the queue head, and input ready
  // must be high exactly on the last beat of a command when the sink is ready.
  always @(negedge clk) begin
    if (rst_n && ma_if.valid) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_beat: got %0h expected none", ma_if.data);
      end else begin
        chk("a_data", 64'(ma_if.data), 64'(q_a[0].data));
        chk("a_user", 64'(ma_if.user), 64'(q_a[0].user));
        chk("a_s_ready", 64'(sa_if.ready), 64'(q_a[0].last && m_ready));
        if (m_ready) void'(q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mb_if.valid) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_beat: got %0h expected none", mb_if.data);
      end else begin
        chk("b_data", 64'(mb_if.data), 64'(q_b[0].data));
        chk("b_user", 64'(mb_if.user), 64'(q_b[0].user));
        chk("b_s_ready", 64'(sb_if.ready), 64'(q_b[0].last && m_ready));
        if (m_ready) void'(q_b.pop_front());
      end
    end
  end

  // Sink ready: constant high, or random while rnd_ready is set.
  always @(posedge clk) begin
    #1;
    m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Present one command and hold it until the input handshake; cyc returns
  // the number of cycles the command waited before being consumed.
  task automatic send(input bit sel, input logic [ID_W-1:0] d, input logic [USER_W-1:0] u,
                      output int cyc);
    bit done;
    cyc = 0; done = 1'b0;
    @(posedge clk); #2;
    s_data = d; s_user = u;
    if (sel) s_valid_b = 1'b1; else s_valid_a = 1'b1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      if (sel ? sb_if.ready : sa_if.ready) done = 1'b1;
      else cyc++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no input handshake expected one within 60 cycles");
    end
    @(posedge clk); #2;
    s_valid_a = 1'b0; s_valid_b = 1'b0;
  endtask

  task automatic drained(input string name);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 60) begin
      @(negedge clk); n++;
    end
    chk(name, 64'(q_a.size() + q_b.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset state
    #12;
    chk("rst_open_a", 64'(open_a), 64'd0);
    chk("rst_open_b", 64'(open_b), 64'd0);
    chk("rst_mvalid", 64'(ma_if.valid), 64'd0);
    chk("rst_sready", 64'(sa_if.ready), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    // Closed bank write: ACTIVE then WRITE
    push(0, mk_out(1, 'h123, C_ACT), 9'h011, 0);
    push(0, mk_out(1, 'h005, C_WR),  9'h011, 1);
    send(0, mk_in(1, 'h123, 'h005, C_WR), 9'h011, cyc);
    chk("miss_closed_cyc", 64'(cyc), 64'd1);
    chk("miss_closed_open", 64'(open_a), 64'b0010);

    // Page hit: zero insertion
    push(0, mk_out(1, 'h007, C_RD), 9'h022, 1);
    send(0, mk_in(1, 'h123, 'h007, C_RD), 9'h022, cyc);
    chk("hit_cyc", 64'(cyc), 64'd0);

    // Row conflict: PRE, ACT, READ
    push(0, mk_out(1, 'h000, C_PRE), 9'h033, 0);
    push(0, mk_out(1, 'h200, C_ACT), 9'h033, 0);
    push(0, mk_out(1, 'h008, C_RD),  9'h033, 1);
    send(0, mk_in(1, 'h200, 'h008, C_RD), 9'h033, cyc);
    chk("conflict_cyc", 64'(cyc), 64'd2);
    chk("conflict_open", 64'(open_a), 64'b0010);

    // Open banks 0 and 2
    push(0, mk_out(0, 'h005, C_ACT), 9'h001, 0);
    push(0, mk_out(0, 'h010, C_WR),  9'h001, 1);
    send(0, mk_in(0, 'h005, 'h010, C_WR), 9'h001, cyc);
    push(0, mk_out(2, 'h007, C_ACT), 9'h002, 0);
    push(0, mk_out(2, 'h020, C_WR),  9'h002, 1);
    send(0, mk_in(2, 'h007, 'h020, C_WR), 9'h002, cyc);
    chk("three_open", 64'(open_a), 64'b0111);

    // Refresh with banks open: PRECHARGE ALL then REFRESH
    push(0, mk_out(0, 'h400, C_PRE), 9'h044, 0);
    push(0, mk_out(2, 'h000, C_REF), 9'h044, 1);
    fork
      send(0, mk_in(2, 0, 0, C_REF), 9'h044, cyc);
      begin
        @(posedge clk); @(posedge clk); #3;
        chk("ref_open_after_pre", 64'(open_a), 64'd0);
      end
    join
    chk("ref_cyc", 64'(cyc), 64'd1);

    // Refresh with all banks closed passes straight through
    push(0, mk_out(0, 'h000, C_REF), 9'h055, 1);
    send(0, mk_in(0, 0, 0, C_REF), 9'h055, cyc);
    chk("ref_closed_cyc", 64'(cyc), 64'd0);

    // Full page: user A10=1 is dropped, bank stays open
    push(0, mk_out(3, 'h033, C_ACT), 9'h066, 0);
    push(0, mk_out(3, 'h005, C_WR),  9'h066, 1);
    send(0, mk_in(3, 'h033, 'h405, C_WR), 9'h066, cyc);
    chk("fullpage_open", 64'(open_a), 64'b1000);

    // Conflict with a randomly stalling sink
    rnd_ready = 1'b1;
    push(0, mk_out(3, 'h000, C_PRE), 9'h077, 0);
    push(0, mk_out(3, 'h044, C_ACT), 9'h077, 0);
    push(0, mk_out(3, 'h009, C_RD),  9'h077, 1);
    send(0, mk_in(3, 'h044, 'h009, C_RD), 9'h077, cyc);
    rnd_ready = 1'b0;
    drained("stall_drained");
    chk("stall_open", 64'(open_a), 64'b1000);
    @(posedge clk); @(posedge clk);

    // Reset while in ACT: only the PRECHARGE is emitted before reset
    push(0, mk_out(3, 'h000, C_PRE), 9'h088, 0);
    @(posedge clk); #2;
    s_data = mk_in(3, 'h055, 'h001, C_RD); s_user = 9'h088; s_valid_a = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_open", 64'(open_a), 64'd0);
    chk("rst_mid_queue", 64'(q_a.size()), 64'd0);
    q_a.delete();
    s_valid_a = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    // Back in PASS with nothing open: refresh goes through alone
    push(0, mk_out(0, 'h000, C_REF), 9'h099, 1);
    send(0, mk_in(0, 0, 0, C_REF), 9'h099, cyc);
    chk("post_rst_ref_cyc", 64'(cyc), 64'd0);

    // Full page, user A10=0: bank 3 stays open
    push(0, mk_out(3, 'h066, C_ACT), 9'h0aa, 0);
    push(0, mk_out(3, 'h005, C_WR),  9'h0aa, 1);
    send(0, mk_in(3, 'h066, 'h005, C_WR), 9'h0aa, cyc);
    chk("a_bank3_open", 64'(open_a[3]), 64'd1);

    // Close page, BL=4: A10 forced 1, bank closes after each access
    push(1, mk_out(3, 'h066, C_ACT), 9'h0bb, 0);
    push(1, mk_out(3, 'h405, C_WR),  9'h0bb, 1);
    send(1, mk_in(3, 'h066, 'h005, C_WR), 9'h0bb, cyc);
    chk("b_bank3_closed", 64'(open_b), 64'd0);
    push(1, mk_out(3, 'h066, C_ACT), 9'h0cc, 0);
    push(1, mk_out(3, 'h406, C_RD),  9'h0cc, 1);
    send(1, mk_in(3, 'h066, 'h006, C_RD), 9'h0cc, cyc);
    chk("b_reopen_cyc", 64'(cyc), 64'd1);
    chk("b_closed_again", 64'(open_b), 64'd0);

    drained("final_drained");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_act_pre_insert_gen.md
Name: sdram_act_pre_insert_gen

Overview:
- Parametrised successor of the SDRAM activate/precharge insertion stage.
- Sits between the user command AXIS and the SDRAM command sequencer. Tracks the open row of each of BANK_N banks.
- Before each read/write it inserts [PRECHARGE] then [ACTIVE] when needed. Before AUTO REFRESH it inserts PRECHARGE ALL when any bank is open.
- Applies a selectable open/close page policy via the A10 auto-precharge bit.

Parameters:
BANK_N, 4, number of banks (power of 2, 2..8); BA_W = clog2(BANK_N)
ADDR_W, 13, row/column address width (>=11; A10 is bit 10)
BURST_LEN, -1, -1 = full page, else 1/2/4/8; full page forces A10=0 on read/write
PAGE_POLICY, "open", "open" = A10 taken from user bit 10; "close" = A10 forced to 1 on read/write (ignored when BURST_LEN=-1)
USER_W, 9, sideband width, passed through unchanged

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_usr_cmd_data  in  BA_W+2*ADDR_W+3  {ba, row, addr, cmd[2:0]}
s_axis_usr_cmd_user  in  USER_W  sideband
s_axis_usr_cmd_valid  in  1  command valid
s_axis_usr_cmd_ready  out  1  command consumed
m_axis_inserted_cmd_data  out  BA_W+ADDR_W+3  {ba, addr, cmd[2:0]}
m_axis_inserted_cmd_user  out  USER_W  copy of s_axis_usr_cmd_user
m_axis_inserted_cmd_valid  out  1  output valid
m_axis_inserted_cmd_ready  in  1  sink ready
bank_open_o  out  BANK_N  current open-bank vector (debug/status)

Behaviour:
- Command codes: 000 ACTIVE, 001 PRECHARGE (A10=1 means all banks), 010 WRITE, 011 READ, 100 AUTO REFRESH. Any other code passes through unchanged.
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: state=PASS, bank_open=0, m_valid=0, s_ready=0. Row registers are not reset.
- No input register. Output data/valid are combinational from the input, the state and the tracking registers, so there is zero-cycle latency when no insertion is needed.
- Tracking updates only on an output handshake (m_valid & m_ready):
  - ACTIVE: bank_open[ba]=1, row[ba]=addr.
  - PRECHARGE, A10=0: bank_open[ba]=0.
  - PRECHARGE, A10=1: bank_open=0.
  - READ/WRITE with emitted A10=1: bank_open[ba]=0.
- Emitted A10 on READ/WRITE: 0 if BURST_LEN=-1; 1 if PAGE_POLICY="close"; otherwise user addr[10]. Other address bits pass unchanged.
- FSM states: PASS, ACT, RW, REF.
- PASS, read/write input:
  - hit (open & row==row[ba]): emit RW, s_ready=m_ready, stay in PASS.
  - conflict (open, different row): emit PRECHARGE(ba, A10=0); on handshake go to ACT.
  - closed: emit ACTIVE(ba,row); on handshake go to RW.
- ACT: emit ACTIVE(ba,row); on handshake go to RW.
- RW: emit the read/write; s_ready=m_ready; on handshake go to PASS.
- PASS, AUTO REFRESH input:
  - any bank open: emit PRECHARGE(ba=0, A10=1); on handshake go to REF.
  - no bank open: pass refresh with s_ready=m_ready.
- REF: emit the refresh; s_ready=m_ready; on handshake go to PASS.
- PASS, other codes (including user ACTIVE/PRECHARGE): pass through with s_ready=m_ready. Tracking updates as above. A user ACTIVE to an already-open bank is not checked (issuer's responsibility).
- s_ready is 0 in every insert cycle. The input command is held by AXIS rules until the final command is handshaken.
- m_valid requires s_valid. If valid drops while in a non-PASS state (AXIS violation) the state holds, with no corruption.
- Reset mid-sequence: returns to PASS with all banks closed. Nothing partial is re-emitted.

Test Plan:
- After reset, WRITE ba=1 row=0x0123 addr=0x005, m_ready=1 → ACTIVE(1,0x0123) then WRITE(1,0x005) on consecutive cycles; s_ready high only in cycle 2; bank_open_o=4'b0010.
- READ ba=1 row=0x0123 next → single READ, zero insertion, s_ready same cycle as valid.
- READ ba=1 row=0x0200 → PRECHARGE(1,A10=0), ACTIVE(1,0x0200), READ; exactly 3 output beats, 1 input handshake.
- Banks 0 and 2 open, then AUTO REFRESH → PRECHARGE(ba=0, addr bit10=1) then REFRESH; bank_open_o=0 after the first beat.
- PAGE_POLICY="close", BURST_LEN=4, WRITE ba=3 with user A10=0 → ACTIVE, WRITE with A10=1; bank_open_o[3]=0 afterwards. Repeat with BURST_LEN=-1 → A10=0, bank 3 stays open.
- m_ready toggled randomly during the 3-beat miss sequence → output data is stable while stalled, no beat is skipped or duplicated. rst_n pulsed in state ACT → state PASS, bank_open_o=0.
